// File: rtl/img_proc_pkg.sv
// rtl/img_proc_pkg.sv - shared types and mode decode for the image_proc control blocks
// Contents:
//   mode_t       filter mode codes (MODE_ILL is never applied)
//   ctrl_state_t mode scheduler states
//   mode_to_en   mode -> {gray_en, horz_en}
package img_proc_pkg;

  typedef enum logic [1:0] {
    MODE_VERT = 2'd0,
    MODE_HORZ = 2'd1,
    MODE_GRAY = 2'd2,
    MODE_ILL  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ACTIVE   = 2'd0,
    WAIT_EOF = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_t;

  // Returns {gray_en, horz_en}; the illegal code falls back to the vertical filter.
  function automatic logic [1:0] mode_to_en(input mode_t m);
    case (m)
      MODE_HORZ: return 2'b01;
      MODE_GRAY: return 2'b10;
      default:   return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/frame_pos_det.sv
// rtl/frame_pos_det.sv - combinational end-of-frame strobe from the pixel counters
// Ports:
//   iDVAL    in   pixel-valid strobe
//   iX_Cont  in   column counter
//   iY_Cont  in   row counter
//   eof_o    out  high on the valid last pixel of the last line
module frame_pos_det #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 960
) (
  input  logic        iDVAL,
  input  logic [10:0] iX_Cont,
  input  logic [10:0] iY_Cont,
  output logic        eof_o
);

  assign eof_o = iDVAL
              && (iX_Cont == 11'(H_ACTIVE - 1))
              && (iY_Cont == 11'(V_ACTIVE - 1));

endmodule

// File: rtl/img_mode_ctrl.sv
// rtl/img_mode_ctrl.sv - frame-synchronous filter mode scheduler with post-change blanking
// Build option: IMG_MODE_CTRL_FLUSH_EN enables the FLUSH state (line-buffer refill blanking).
// Ports:
//   iCLK, iRST           pixel clock, asynchronous active-low reset
//   iDVAL/iX_Cont/iY_Cont pixel strobe and counters shared with image_proc
//   req_valid/req_mode   mode-change request; req_ready accepts it
//   req_err              one-cycle pulse after an illegal mode is accepted
//   gray_en/horz_en      registered filter enables for image_proc
//   oBLANK               suppress filter output while buffers refill
//   cur_mode             mode currently applied
//   frame_cnt            completed-frame count (wraps)
module img_mode_ctrl
  import img_proc_pkg::*;
#(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 960,
  parameter int FLUSH_LINES = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iDVAL,
  input  logic [10:0] iX_Cont,
  input  logic [10:0] iY_Cont,
  input  logic        req_valid,
  input  mode_t       req_mode,
  output logic        req_ready,
  output logic        req_err,
  output logic        gray_en,
  output logic        horz_en,
  output logic        oBLANK,
  output mode_t       cur_mode,
  output logic [15:0] frame_cnt
);

  ctrl_state_t state_q, state_d;
  mode_t       cur_mode_q, cur_mode_d;
  mode_t       pend_mode_q, pend_mode_d;
  logic        gray_en_q, horz_en_q;
  logic [1:0]  en_d;
  logic        req_err_q, req_err_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        eof;
  logic        hs;

  frame_pos_det #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_frame_pos_det (
    .iDVAL   (iDVAL),
    .iX_Cont (iX_Cont),
    .iY_Cont (iY_Cont),
    .eof_o   (eof)
  );

`ifdef IMG_MODE_CTRL_FLUSH_EN
  localparam int FLUSH_TOTAL = FLUSH_LINES * H_ACTIVE;
  localparam int FCW         = $clog2(FLUSH_TOTAL + 1);
  logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
`else
  logic unused_flush_lines;
  assign unused_flush_lines = (FLUSH_LINES > 0);
`endif

  assign req_ready = (state_q == ACTIVE);
  assign hs        = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    cur_mode_d  = cur_mode_q;
    pend_mode_d = pend_mode_q;
    req_err_d   = 1'b0;
    frame_cnt_d = frame_cnt_q + {15'd0, eof};
`ifdef IMG_MODE_CTRL_FLUSH_EN
    flush_cnt_d = flush_cnt_q;
`endif
    case (state_q)
      ACTIVE: begin
        // An EOF coinciding with the handshake is not used: WAIT_EOF is
        // only entered on this edge, so the next EOF applies the mode.
        if (hs) begin
          if (req_mode == MODE_ILL) begin
            req_err_d = 1'b1;
          end else if (req_mode != cur_mode_q) begin
            pend_mode_d = req_mode;
            state_d     = WAIT_EOF;
          end
        end
      end
      WAIT_EOF: begin
        if (eof) begin
          cur_mode_d = pend_mode_q;
`ifdef IMG_MODE_CTRL_FLUSH_EN
          flush_cnt_d = '0;
          state_d     = FLUSH;
`else
          state_d     = ACTIVE;
`endif
        end
      end
`ifdef IMG_MODE_CTRL_FLUSH_EN
      FLUSH: begin
        // Counts valid pixels only, so iDVAL gaps stretch the window.
        if (iDVAL) begin
          if (flush_cnt_q == FCW'(FLUSH_TOTAL - 1)) begin
            state_d = ACTIVE;
          end else begin
            flush_cnt_d = flush_cnt_q + FCW'(1);
          end
        end
      end
`endif
      default: state_d = ACTIVE;
    endcase
    // Enables follow the next cur_mode so both change on the same edge.
    en_d = mode_to_en(cur_mode_d);
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q     <= ACTIVE;
      cur_mode_q  <= MODE_VERT;
      pend_mode_q <= MODE_VERT;
      gray_en_q   <= 1'b0;
      horz_en_q   <= 1'b0;
      req_err_q   <= 1'b0;
      frame_cnt_q <= '0;
`ifdef IMG_MODE_CTRL_FLUSH_EN
      flush_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cur_mode_q  <= cur_mode_d;
      pend_mode_q <= pend_mode_d;
      gray_en_q   <= en_d[1];
      horz_en_q   <= en_d[0];
      req_err_q   <= req_err_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef IMG_MODE_CTRL_FLUSH_EN
      flush_cnt_q <= flush_cnt_d;
`endif
    end
  end

`ifdef IMG_MODE_CTRL_FLUSH_EN
  assign oBLANK = (state_q == FLUSH);
`else
  assign oBLANK = 1'b0;
`endif

  assign req_err   = req_err_q;
  assign gray_en   = gray_en_q;
  assign horz_en   = horz_en_q;
  assign cur_mode  = cur_mode_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_img_mode_ctrl.sv
// tb/tb_img_mode_ctrl.sv - directed scoreboard bench for img_mode_ctrl (8x4 frame, 2 flush lines)
module tb_img_mode_ctrl;
  import img_proc_pkg::*;

  localparam int H = 8;
  localparam int V = 4;
`ifdef IMG_MODE_CTRL_FLUSH_EN
  localparam int  EXP_BLANK = 16;
  localparam int  EXP_GAP   = 5;
  localparam logic EXP_ON   = 1'b1;
`else
  localparam int  EXP_BLANK = 0;
  localparam int  EXP_GAP   = 0;
  localparam logic EXP_ON   = 1'b0;
`endif

  logic        iCLK, iRST, iDVAL;
  logic [10:0] iX_Cont, iY_Cont;
  logic        req_valid;
  mode_t       req_mode;
  logic        req_ready, req_err, gray_en, horz_en, oBLANK;
  mode_t       cur_mode;
  logic [15:0] frame_cnt;

  img_mode_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .FLUSH_LINES(2)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .req_valid(req_valid), .req_mode(req_mode), .req_ready(req_ready), .req_err(req_err),
    .gray_en(gray_en), .horz_en(horz_en), .oBLANK(oBLANK), .cur_mode(cur_mode),
    .frame_cnt(frame_cnt)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    mode_t       mode;
    logic [15:0] frame;
  } sb_t;

  sb_t         sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          x_b = 0;
  int          y_b = 0;
  logic [15:0] exp_frames = 16'd0;
  logic [1:0]  en_prev = 2'b00;
  mode_t       model_mode = MODE_VERT;

  function automatic logic [1:0] exp_en(input mode_t m);
    if (m == MODE_GRAY) return 2'b10;
    if (m == MODE_HORZ) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    iX_Cont = 11'(x_b);
    iY_Cont = 11'(y_b);
  endtask

  // One clock: advance the bench pixel position, model frame_cnt and pop
  // the scoreboard whenever the DUT enables change.
  task automatic step();
    logic       eof_edge;
    logic [1:0] en_now;
    sb_t        e;
    @(posedge iCLK);
    eof_edge = iDVAL && (x_b == H-1) && (y_b == V-1) && iRST;
    #1;
    if (eof_edge) exp_frames = exp_frames + 16'd1;
    if (iDVAL) begin
      if (x_b == H-1) begin
        x_b = 0;
        y_b = (y_b == V-1) ? 0 : y_b + 1;
      end else begin
        x_b = x_b + 1;
      end
    end
    drive();
    check("frame_cnt", frame_cnt, exp_frames);
    en_now = {gray_en, horz_en};
    if (en_now !== en_prev) begin
      if (sb_q.size() == 0) begin
        check("unexpected_en_change", en_now, en_prev);
      end else begin
        e = sb_q.pop_front();
        check("apply_cur_mode", cur_mode, e.mode);
        check("apply_en", en_now, exp_en(e.mode));
        check("apply_frame", frame_cnt, e.frame);
        check("apply_at_x0", x_b, 0);
        check("apply_at_y0", y_b, 0);
        check("apply_blank", oBLANK, EXP_ON);
        check("apply_ready", req_ready, !EXP_ON);
      end
      en_prev = en_now;
    end
  endtask

  task automatic goto_pixel(input int x, input int y);
    int n = 0;
    while (!(x_b == x && y_b == y) && n < 200) begin
      step();
      n++;
    end
    check("goto_bound", (n < 200), 1);
  endtask

  task automatic request(input mode_t m);
    logic chg;
    check("ready_before_req", req_ready, 1);
    chg = (m != MODE_ILL) && (m != model_mode);
    req_valid = 1'b1;
    req_mode  = m;
    step();
    req_valid = 1'b0;
    if (chg) begin
      sb_q.push_back('{m, exp_frames + 16'd1});
      model_mode = m;
    end
    check("ready_after_req", req_ready, !chg);
    check("err_after_req", req_err, (m == MODE_ILL));
  endtask

  task automatic wait_apply();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check("apply_timeout", sb_q.size(), 0);
  endtask

  // Counts blank cycles; with gap set, iDVAL is dropped for 5 of them.
  task automatic measure_blank(input logic gap, output int dv_cnt, output int all_cnt);
    dv_cnt = 0;
    all_cnt = 0;
    for (int i = 0; i < 200 && oBLANK; i++) begin
      iDVAL = !(gap && all_cnt >= 3 && all_cnt < 8);
      if (iDVAL) dv_cnt++;
      all_cnt++;
      step();
    end
    iDVAL = 1'b1;
  endtask

  task automatic reset_pulse(input int n);
    iRST = 1'b0;
    exp_frames = 16'd0;
    sb_q.delete();
    model_mode = MODE_VERT;
    #1;
    check("rst_blank", oBLANK, 0);
    check("rst_gray", gray_en, 0);
    check("rst_horz", horz_en, 0);
    check("rst_mode", cur_mode, MODE_VERT);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err", req_err, 0);
    en_prev = 2'b00;
    repeat (n) step();
    iRST = 1'b1;
    step();
    check("rst_ready", req_ready, 1);
  endtask

  initial begin
    int dv, all;
    iRST = 1'b0;
    iDVAL = 1'b1;
    req_valid = 1'b0;
    req_mode = MODE_VERT;
    drive();
    repeat (2) step();
    iRST = 1'b1;
    repeat (11) step();

    // reset mid-frame
    reset_pulse(2);

    // MODE_HORZ at (3,1): held to next frame, then blank window
    goto_pixel(3, 1);
    request(MODE_HORZ);
    wait_apply();
    measure_blank(1'b0, dv, all);
    check("blank_len_horz", dv, EXP_BLANK);
    check("ready_after_blank", req_ready, 1);

    // same mode again: no-op, no blank
    request(MODE_HORZ);
    check("noop_horz_en", horz_en, 1);
    all = 0;
    repeat (40) begin
      if (oBLANK) all++;
      step();
    end
    check("noop_no_blank", all, 0);
    check("noop_ready", req_ready, 1);

    // illegal mode
    request(MODE_ILL);
    check("ill_mode_kept", cur_mode, MODE_HORZ);
    step();
    check("ill_err_one_cycle", req_err, 0);

    // GRAY requested on the EOF pixel: applied one frame later
    goto_pixel(H-1, V-1);
    request(MODE_GRAY);
    wait_apply();
    measure_blank(1'b0, dv, all);
    check("blank_len_gray", dv, EXP_BLANK);

    // iDVAL gap during flush stretches the window
    request(MODE_VERT);
    wait_apply();
    measure_blank(1'b1, dv, all);
    check("gap_valid_cnt", dv, EXP_BLANK);
    check("gap_total_cnt", all, EXP_BLANK + EXP_GAP);

    // reset in the middle of the flush window
    request(MODE_HORZ);
    wait_apply();
    repeat (4) step();
    check("pre_rst_blank", oBLANK, EXP_ON);
    reset_pulse(2);

    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
